led_mode_sequencer: RTL and testbench
=====================================

Name: led_mode_sequencer

Overview:
Replaces the ad-hoc button/LED logic with a single controller that owns the 8-bit LED bank.
- Debounces the active-low button.
- Classifies gestures: press length, and click count within a gap window.
- Commits a display mode and sequences the LED pattern on a programmable step tick.
- Sits between the board button pin and the LED pins, in the pclk domain.

Parameters:
- DEBOUNCE_CYC, 4: consecutive identical synced samples needed to change the debounced level.
- SHORT_MAX, 20: press length below this is a short press.
- LONG_MIN, 50: press length at or above this is a long press.
- CLICK_GAP, 16: debounced-release cycles that close a gesture.
- STEP_DIV, 8: pclk cycles per pattern step (minimum 2).
- CNT_W, 8: width of the press and gap counters; both saturate at 2^CNT_W-1.

Ports:
- pclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- button  in  1  raw button, 0 = pressed, asynchronous to pclk
- enable  in  1  1 = pattern stepping allowed
- leg  out  8  LED drive
- mode  out  3  current committed mode
- step_tick  out  1  one-cycle pulse per pattern step

Behaviour:
- Reset: asynchronous, active-low, single clock pclk. All flops clear: leg=8'h00, mode=OFF(5), step_tick=0, gesture FSM=G_IDLE, counters=0, sync flops=1 (released). Reset mid-gesture discards the gesture.
- Input path: 2-flop synchroniser, then debouncer. pressed=1 only after DEBOUNCE_CYC consecutive synced 0 samples; released likewise on 1 samples. Glitches shorter than DEBOUNCE_CYC are ignored.
- Gesture FSM:
  - G_IDLE: on pressed, go to G_PRESS. click_cnt=1, press_len=1.
  - G_PRESS: press_len increments each cycle, saturating. Only the first press of a gesture updates press_len. On release, go to G_GAP with gap_cnt=0.
  - G_GAP: gap_cnt increments each cycle. On pressed while gap_cnt<CLICK_GAP, click_cnt increments (saturates at 3) and the FSM returns to G_PRESS. When gap_cnt reaches CLICK_GAP, go to G_COMMIT.
  - G_COMMIT: lasts one cycle, then G_IDLE.
- Decode at G_COMMIT:
  - click_cnt=1, press_len<SHORT_MAX: ALL_ON(0).
  - click_cnt=1, press_len<LONG_MIN: SHIFT_L(1).
  - click_cnt=1, otherwise: SHIFT_R(2).
  - click_cnt=2: CONVERGE(3).
  - click_cnt=3: DIVERGE(4).
- Commit load: at the clock edge ending G_COMMIT, mode and leg load together. Seeds: ALL_ON ff, SHIFT_L 01, SHIFT_R 80, CONVERGE 81, DIVERGE 18. The prescaler clears on the same edge.
- Prescaler: counts 0..STEP_DIV-1 while enable=1. step_tick=1 in the cycle the count equals STEP_DIV-1. When enable=0 the prescaler holds, step_tick=0, and leg holds. Gestures are still classified and committed while enable=0.
- Step rules (applied on the edge after a cycle with step_tick=1):
  - SHIFT_L: rotate left, 80→01.
  - SHIFT_R: rotate right, 01→80.
  - CONVERGE: 81→42→24→18→81.
  - DIVERGE: 18→24→42→81→18.
  - ALL_ON and OFF: hold.
- Illegal leg value in CONVERGE/DIVERGE (only reachable if corrupted): reload the seed on the next step.
- Simultaneous commit and step_tick: commit wins; the step is dropped.

Optional Feature:
- Macro: LEG_ACTIVE_LOW_EN.
- Defined: leg port drives the bitwise inverse of the internal pattern, so reset value is 8'hff. All pattern sequencing is otherwise identical.
- Undefined: leg is active-high as described above.

Decomposition:
- Package led_seq_pkg holds:
  - mode encoding: OFF, ALL_ON, SHIFT_L, SHIFT_R, CONVERGE, DIVERGE.
  - gesture state encoding: G_IDLE, G_PRESS, G_GAP, G_COMMIT.
  - seed constants per mode.
- Sub-module button_debouncer (synchroniser plus DEBOUNCE_CYC counter). Output: pressed. Same clock and reset.
- Gesture FSM, prescaler and pattern engine stay in the top module.

Test Plan:
- Reset with rst_n=0 mid-press, then release rst_n → leg=00, mode=5. No commit until a full new gesture completes.
- Raw press 10 cycles, then release → commit once; mode=0, leg=ff, unchanged through 5 subsequent step_ticks.
- Raw press 30 cycles → mode=1, leg=01. Successive step_ticks give 02, 04 ... 80, then 01 after 8 steps. step_tick spacing is exactly 8 pclk.
- Two 10-cycle presses separated by an 8-cycle raw release → mode=3, leg sequence 81,42,24,18,81.
- Raw press 60 cycles, then a 2-cycle raw glitch high/low after release → glitch ignored; single commit, mode=2, leg 80 then 40.
- SHIFT_L running; hold enable=0 for 20 cycles → leg frozen and no step_tick. Step 08 appears 8 cycles after enable returns to 1.

Source files
------------

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: mode and gesture encodings, pattern seeds
// and the per-step pattern rules of the LED sequencer.
package led_seq_pkg;

  typedef enum logic [2:0] {
    ALL_ON   = 3'd0,
    SHIFT_L  = 3'd1,
    SHIFT_R  = 3'd2,
    CONVERGE = 3'd3,
    DIVERGE  = 3'd4,
    OFF      = 3'd5
  } mode_t;

  typedef enum logic [1:0] {
    G_IDLE   = 2'd0,
    G_PRESS  = 2'd1,
    G_GAP    = 2'd2,
    G_COMMIT = 2'd3
  } gstate_t;

  localparam logic [7:0] SEED_ALL_ON   = 8'hff;
  localparam logic [7:0] SEED_SHIFT_L  = 8'h01;
  localparam logic [7:0] SEED_SHIFT_R  = 8'h80;
  localparam logic [7:0] SEED_CONVERGE = 8'h81;
  localparam logic [7:0] SEED_DIVERGE  = 8'h18;
  localparam logic [7:0] SEED_OFF      = 8'h00;

  function automatic logic [7:0] seed_of(mode_t m);
    logic [7:0] s;
    case (m)
      ALL_ON:   s = SEED_ALL_ON;
      SHIFT_L:  s = SEED_SHIFT_L;
      SHIFT_R:  s = SEED_SHIFT_R;
      CONVERGE: s = SEED_CONVERGE;
      DIVERGE:  s = SEED_DIVERGE;
      default:  s = SEED_OFF;
    endcase
    return s;
  endfunction

  // Corrupted CONVERGE/DIVERGE values fall back to the seed.
  function automatic logic [7:0] next_pat(
    mode_t      m,
    logic [7:0] p
  );
    logic [7:0] n;
    n = p;
    case (m)
      SHIFT_L: n = {p[6:0], p[7]};
      SHIFT_R: n = {p[0], p[7:1]};
      CONVERGE: begin
        case (p)
          8'h81:   n = 8'h42;
          8'h42:   n = 8'h24;
          8'h24:   n = 8'h18;
          default: n = SEED_CONVERGE;
        endcase
      end
      DIVERGE: begin
        case (p)
          8'h18:   n = 8'h24;
          8'h24:   n = 8'h42;
          8'h42:   n = 8'h81;
          default: n = SEED_DIVERGE;
        endcase
      end
      default: n = p;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser plus a
// consecutive-sample debouncer for an active-low button.
module button_debouncer #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic button,
  output logic pressed
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] CNT_LAST =
    DW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] cnt;

  // sync2 == pressed means the synced level disagrees
  // with the debounced state (button is active-low).
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      if (sync2 == pressed) begin
        if (cnt == CNT_LAST) begin
          pressed <= ~sync2;
          cnt     <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: button gestures select an LED mode;
// patterns step on a prescaled tick. LEG_ACTIVE_LOW_EN inverts leg.
module led_mode_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int SHORT_MAX    = 20,
  parameter int LONG_MIN     = 50,
  parameter int CLICK_GAP    = 16,
  parameter int STEP_DIV     = 8,
  parameter int CNT_W        = 8
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       button,
  input  logic       enable,
  output logic [7:0] leg,
  output logic [2:0] mode,
  output logic       step_tick
);

  localparam int PW = $clog2(STEP_DIV);
  localparam logic [PW-1:0] PCNT_LAST =
    PW'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] SHORT_LEN =
    CNT_W'(SHORT_MAX);
  localparam logic [CNT_W-1:0] LONG_LEN  =
    CNT_W'(LONG_MIN);
  localparam logic [CNT_W-1:0] GAP_LEN   =
    CNT_W'(CLICK_GAP);

  logic             pressed;
  gstate_t          gst;
  logic [CNT_W-1:0] press_len;
  logic [CNT_W-1:0] gap_cnt;
  logic [1:0]       click_cnt;
  mode_t            mode_q;
  mode_t            dec_mode;
  logic [7:0]       pat;
  logic [PW-1:0]    pcnt;
  logic             commit;
  logic             tick;

  button_debouncer #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .button (button),
    .pressed(pressed)
  );

  assign commit = (gst == G_COMMIT);
  assign tick   = enable && (pcnt == PCNT_LAST);

  always_comb begin
    dec_mode = SHIFT_R;
    if (click_cnt == 2'd3) begin
      dec_mode = DIVERGE;
    end else if (click_cnt == 2'd2) begin
      dec_mode = CONVERGE;
    end else if (press_len < SHORT_LEN) begin
      dec_mode = ALL_ON;
    end else if (press_len < LONG_LEN) begin
      dec_mode = SHIFT_L;
    end else begin
      dec_mode = SHIFT_R;
    end
  end

  // Only the first press of a gesture sets press_len.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      gst       <= G_IDLE;
      press_len <= '0;
      gap_cnt   <= '0;
      click_cnt <= 2'd0;
    end else begin
      unique case (gst)
        G_IDLE: begin
          if (pressed) begin
            gst       <= G_PRESS;
            click_cnt <= 2'd1;
            press_len <= CNT_W'(1);
            gap_cnt   <= '0;
          end
        end
        G_PRESS: begin
          if (!pressed) begin
            gst     <= G_GAP;
            gap_cnt <= '0;
          end else if (click_cnt == 2'd1 &&
                       press_len != CNT_MAX) begin
            press_len <= press_len + CNT_W'(1);
          end
        end
        G_GAP: begin
          if (pressed && gap_cnt < GAP_LEN) begin
            gst <= G_PRESS;
            if (click_cnt != 2'd3)
              click_cnt <= click_cnt + 2'd1;
          end else if (gap_cnt >= GAP_LEN) begin
            gst <= G_COMMIT;
          end else if (gap_cnt != CNT_MAX) begin
            gap_cnt <= gap_cnt + CNT_W'(1);
          end
        end
        G_COMMIT: begin
          gst <= G_IDLE;
        end
        default: begin
          gst <= G_IDLE;
        end
      endcase
    end
  end

  // A commit overrides any step due on the same edge.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= OFF;
      pat    <= SEED_OFF;
      pcnt   <= '0;
    end else if (commit) begin
      mode_q <= dec_mode;
      pat    <= seed_of(dec_mode);
      pcnt   <= '0;
    end else if (enable) begin
      if (pcnt == PCNT_LAST) begin
        pcnt <= '0;
        pat  <= next_pat(mode_q, pat);
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  assign mode      = mode_q;
  assign step_tick = tick;

`ifdef LEG_ACTIVE_LOW_EN
  assign leg = ~pat;
`else
  assign leg = pat;
`endif

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb_led_mode_sequencer: directed gesture scenarios with
// hand-computed modes, LED patterns and step spacing.
module tb_led_mode_sequencer;

`ifdef LEG_ACTIVE_LOW_EN
  localparam logic [7:0] INV = 8'hff;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  logic       pclk   = 1'b0;
  logic       rst_n  = 1'b0;
  logic       button = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] leg;
  logic [2:0] mode;
  logic       step_tick;
  logic [7:0] pat;
  logic [2:0] last_mode = 3'd5;

  int checks  = 0;
  int errors  = 0;
  int commits = 0;

  always #5 pclk = ~pclk;

  assign pat = leg ^ INV;

  led_mode_sequencer #(
    .DEBOUNCE_CYC(4),
    .SHORT_MAX   (20),
    .LONG_MIN    (50),
    .CLICK_GAP   (16),
    .STEP_DIV    (8),
    .CNT_W       (8)
  ) dut (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .button   (button),
    .enable   (enable),
    .leg      (leg),
    .mode     (mode),
    .step_tick(step_tick)
  );

  always @(negedge pclk) begin
    if (mode !== last_mode) commits++;
    last_mode = mode;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic press(input int n);
    button = 1'b0;
    cyc(n);
    button = 1'b1;
  endtask

  task automatic wait_mode(input logic [2:0] m, output bit ok);
    int i;
    i = 0;
    while (mode !== m && i < 150) begin
      @(negedge pclk);
      i++;
    end
    ok = (mode === m);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (step_tick !== 1'b1 && n < 40) begin
      @(negedge pclk);
      n++;
    end
  endtask

  task automatic test_reset;
    cyc(2);
    checks++;
    if (pat !== 8'h00) begin
      errors++;
      $display("FAIL rst_leg: got %h want 00", pat);
    end
    checks++;
    if (mode !== 3'd5) begin
      errors++;
      $display("FAIL rst_mode: got %0d want 5", mode);
    end
    checks++;
    if (step_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_tick: got %b want 0", step_tick);
    end
    rst_n = 1'b1;
    cyc(2);
    button = 1'b0;
    cyc(20);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pat !== 8'h00 || mode !== 3'd5) begin
      errors++;
      $display("FAIL midrst: leg %h mode %0d want 00/5",
               pat, mode);
    end
    button = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(60);
    checks++;
    if (commits !== 0 || mode !== 3'd5) begin
      errors++;
      $display("FAIL nocommit: commits %0d mode %0d want 0/5",
               commits, mode);
    end
  endtask

  task automatic test_all_on;
    bit ok;
    int n;
    press(10);
    wait_mode(3'd0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL allon_mode: got %0d want 0", mode);
    end
    checks++;
    if (pat !== 8'hff) begin
      errors++;
      $display("FAIL allon_seed: got %h want ff", pat);
    end
    for (int k = 0; k < 5; k++) begin
      wait_tick(n);
      cyc(1);
      checks++;
      if (n !== 7 || pat !== 8'hff || mode !== 3'd0) begin
        errors++;
        $display("FAIL allon_hold%0d: n %0d leg %h want 7/ff",
                 k, n, pat);
      end
    end
  endtask

  task automatic test_shift_l;
    bit ok;
    int n;
    logic [7:0] exp_t[8];
    exp_t = '{8'h02, 8'h04, 8'h08, 8'h10,
              8'h20, 8'h40, 8'h80, 8'h01};
    press(30);
    wait_mode(3'd1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL shl_mode: got %0d want 1", mode);
    end
    checks++;
    if (pat !== 8'h01) begin
      errors++;
      $display("FAIL shl_seed: got %h want 01", pat);
    end
    for (int k = 0; k < 8; k++) begin
      wait_tick(n);
      checks++;
      if (n !== 7) begin
        errors++;
        $display("FAIL shl_space%0d: got %0d want 7", k, n);
      end
      cyc(1);
      checks++;
      if (pat !== exp_t[k]) begin
        errors++;
        $display("FAIL shl_step%0d: got %h want %h",
                 k, pat, exp_t[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    logic [7:0] exp_t[4];
    exp_t = '{8'h42, 8'h24, 8'h18, 8'h81};
    press(10);
    cyc(8);
    press(10);
    wait_mode(3'd3, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL conv_mode: got %0d want 3", mode);
    end
    checks++;
    if (pat !== 8'h81) begin
      errors++;
      $display("FAIL conv_seed: got %h want 81", pat);
    end
    for (int k = 0; k < 4; k++) begin
      wait_tick(n);
      cyc(1);
      checks++;
      if (pat !== exp_t[k]) begin
        errors++;
        $display("FAIL conv_step%0d: got %h want %h",
                 k, pat, exp_t[k]);
      end
    end
  endtask

  task automatic test_glitch;
    bit ok;
    int n;
    int c0;
    c0 = commits;
    press(60);
    cyc(10);
    button = 1'b0;
    cyc(2);
    button = 1'b1;
    wait_mode(3'd2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL shr_mode: got %0d want 2", mode);
    end
    checks++;
    if (pat !== 8'h80) begin
      errors++;
      $display("FAIL shr_seed: got %h want 80", pat);
    end
    wait_tick(n);
    cyc(1);
    checks++;
    if (pat !== 8'h40) begin
      errors++;
      $display("FAIL shr_step: got %h want 40", pat);
    end
    cyc(40);
    checks++;
    if (commits !== c0 + 1 || mode !== 3'd2) begin
      errors++;
      $display("FAIL glitch_once: commits %0d mode %0d want %0d/2",
               commits - c0, mode, 1);
    end
  endtask

  task automatic test_enable;
    bit ok;
    int n;
    int ticks;
    press(30);
    wait_mode(3'd1, ok);
    checks++;
    if (!ok || pat !== 8'h01) begin
      errors++;
      $display("FAIL en_commit: mode %0d leg %h want 1/01",
               mode, pat);
    end
    wait_tick(n);
    cyc(1);
    wait_tick(n);
    cyc(1);
    checks++;
    if (pat !== 8'h04) begin
      errors++;
      $display("FAIL en_pre: got %h want 04", pat);
    end
    enable = 1'b0;
    ticks = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge pclk);
      if (step_tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks !== 0) begin
      errors++;
      $display("FAIL en_notick: got %0d want 0", ticks);
    end
    checks++;
    if (pat !== 8'h04) begin
      errors++;
      $display("FAIL en_frozen: got %h want 04", pat);
    end
    enable = 1'b1;
    wait_tick(n);
    checks++;
    if (n !== 7) begin
      errors++;
      $display("FAIL en_resume: got %0d want 7", n);
    end
    cyc(1);
    checks++;
    if (pat !== 8'h08) begin
      errors++;
      $display("FAIL en_step: got %h want 08", pat);
    end
  endtask

  initial begin
    test_reset();
    test_all_on();
    test_shift_l();
    test_back_to_back();
    test_glitch();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
